// File: rtl/dcpu16_marb_pkg.sv
// dcpu16 memory arbiter: shared types and constants.
// Requester IDs, FSM states, grant bit positions.
package dcpu16_marb_pkg;

  localparam int DW = 16;
  localparam int AW = 16;

  typedef enum logic [1:0] {
    ARB,
    ACC,
    CAP,
    ACK
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_F,
    REQ_G,
    REQ_X
  } req_t;

  localparam int GNT_F = 0;
  localparam int GNT_G = 1;
  localparam int GNT_X = 2;

  function automatic logic group_done(
    input logic f_stb,
    input logic g_stb,
    input logic sf,
    input logic sg
  );
    return (!f_stb || sf) && (!g_stb || sg)
        && (sf || sg);
  endfunction

endpackage

// File: rtl/dcpu16_marb_if.sv
// dcpu16 memory arbiter: one requester bus.
// Strobe held until a 1-cycle ack pulse.
interface dcpu16_marb_if;
  import dcpu16_marb_pkg::*;

  logic [AW-1:0] adr;
  logic          stb;
  logic          wre;
  logic [DW-1:0] dto;
  logic [DW-1:0] dti;
  logic          ack;

  modport master (
    output adr, stb, wre, dto,
    input  dti, ack
  );

  modport slave (
    input  adr, stb, wre, dto,
    output dti, ack
  );

endinterface

// File: rtl/dcpu16_marb_prio.sv
// dcpu16 memory arbiter: grant priority encoder.
// Starved X first, then unserved F, unserved G, then X.
module dcpu16_marb_prio
  import dcpu16_marb_pkg::*;
(
  input  logic       f_stb,
  input  logic       g_stb,
  input  logic       x_stb,
  input  logic       sf,
  input  logic       sg,
  input  logic       x_starved,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = '0;
    priority case (1'b1)
      x_stb && x_starved: gnt[GNT_X] = 1'b1;
      f_stb && !sf:       gnt[GNT_F] = 1'b1;
      g_stb && !sg:       gnt[GNT_G] = 1'b1;
      x_stb:              gnt[GNT_X] = 1'b1;
      default:            gnt = '0;
    endcase
  end

endmodule

// File: rtl/dcpu16_marb.sv
// dcpu16 memory arbiter: shares one sync RAM between
// CPU G/F buses and external X bus; CPU acks coalesced.
module dcpu16_marb
  import dcpu16_marb_pkg::*;
#(
  parameter int XWAIT_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  dcpu16_marb_if.slave  g,
  dcpu16_marb_if.slave  f,
  dcpu16_marb_if.slave  x,
  output logic [AW-1:0] m_adr,
  output logic          m_en,
  output logic          m_wre,
  output logic [DW-1:0] m_dto,
  input  logic [DW-1:0] m_dti
);

  localparam int XW = $clog2(XWAIT_MAX + 1);

  state_t        state;
  req_t          owner;
  logic          sf, sg;
  logic [XW-1:0] xcnt;
  logic [DW-1:0] g_hold, f_hold, x_hold;
  logic          g_ack_q, f_ack_q, x_ack_q;
  logic [2:0]    gnt;
  logic          x_starved;
  logic          sf_nx, sg_nx;
  logic          done_nx;

  assign x_starved = xcnt >= XW'(XWAIT_MAX);

  dcpu16_marb_prio u_prio (
    .f_stb     (f.stb),
    .g_stb     (g.stb),
    .x_stb     (x.stb),
    .sf        (sf),
    .sg        (sg),
    .x_starved (x_starved),
    .gnt       (gnt)
  );

  // served bits as they will be after this cycle's capture
  always_comb begin
    sf_nx = sf;
    sg_nx = sg;
    if (state == CAP) begin
      if (owner == REQ_F) sf_nx = 1'b1;
      if (owner == REQ_G) sg_nx = 1'b1;
    end
  end

  assign done_nx = group_done(f.stb, g.stb,
                              sf_nx, sg_nx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB;
      owner   <= REQ_NONE;
      sf      <= 1'b0;
      sg      <= 1'b0;
      xcnt    <= '0;
      g_hold  <= '0;
      f_hold  <= '0;
      x_hold  <= '0;
      g_ack_q <= 1'b0;
      f_ack_q <= 1'b0;
      x_ack_q <= 1'b0;
      m_adr   <= '0;
      m_en    <= 1'b0;
      m_wre   <= 1'b0;
      m_dto   <= '0;
    end else begin
      g_ack_q <= 1'b0;
      f_ack_q <= 1'b0;
      x_ack_q <= 1'b0;
      if (!x.stb) xcnt <= '0;
      unique case (state)
        ARB: begin
          if (|gnt) begin
            m_en  <= 1'b1;
            state <= ACC;
            unique case (1'b1)
              gnt[GNT_F]: begin
                m_adr <= f.adr;
                m_wre <= f.wre;
                m_dto <= f.dto;
                owner <= REQ_F;
              end
              gnt[GNT_G]: begin
                m_adr <= g.adr;
                m_wre <= g.wre;
                m_dto <= g.dto;
                owner <= REQ_G;
              end
              gnt[GNT_X]: begin
                m_adr <= x.adr;
                m_wre <= x.wre;
                m_dto <= x.dto;
                owner <= REQ_X;
              end
            endcase
          end else if (done_nx) begin
            state   <= ACK;
            f_ack_q <= sf && f.stb;
            g_ack_q <= sg && g.stb;
          end
          if (gnt[GNT_X])
            xcnt <= '0;
          else if (x.stb && !x_starved)
            xcnt <= xcnt + XW'(1);
        end
        ACC: begin
          m_en  <= 1'b0;
          state <= CAP;
        end
        CAP: begin
          if (!m_wre) begin
            case (owner)
              REQ_F:   f_hold <= m_dti;
              REQ_G:   g_hold <= m_dti;
              REQ_X:   x_hold <= m_dti;
              default: ;
            endcase
          end
          sf <= sf_nx;
          sg <= sg_nx;
          if (owner == REQ_X || done_nx) begin
            state   <= ACK;
            x_ack_q <= owner == REQ_X;
            f_ack_q <= done_nx && sf_nx && f.stb;
            g_ack_q <= done_nx && sg_nx && g.stb;
          end else begin
            state <= ARB;
          end
        end
        ACK: begin
          if (f_ack_q || g_ack_q) begin
            sf <= 1'b0;
            sg <= 1'b0;
          end
          owner <= REQ_NONE;
          state <= ARB;
        end
      endcase
    end
  end

  assign g.dti = g_hold;
  assign f.dti = f_hold;
  assign x.dti = x_hold;
  assign g.ack = g_ack_q;
  assign f.ack = f_ack_q;
  assign x.ack = x_ack_q;

endmodule

// File: tb/tb_dcpu16_marb.sv
// Directed self-checking bench for dcpu16_marb
// with a behavioural single-port sync RAM.
module tb_dcpu16_marb;
  import dcpu16_marb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcpu16_marb_if g_bus ();
  dcpu16_marb_if f_bus ();
  dcpu16_marb_if x_bus ();

  logic [15:0] m_adr, m_dto, m_dti;
  logic        m_en, m_wre;

  dcpu16_marb #(.XWAIT_MAX(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .g     (g_bus),
    .f     (f_bus),
    .x     (x_bus),
    .m_adr (m_adr),
    .m_en  (m_en),
    .m_wre (m_wre),
    .m_dto (m_dto),
    .m_dti (m_dti)
  );

  logic [15:0] mem [0:65535];
  logic        pre_en = 1'b0;
  logic [15:0] pre_adr = '0;
  logic [15:0] pre_dat = '0;

  always @(posedge clk) begin
    if (pre_en)
      mem[pre_adr] <= pre_dat;
    else if (m_en && m_wre)
      mem[m_adr] <= m_dto;
    else if (m_en)
      m_dti <= mem[m_adr];
  end

  int errors = 0;
  int checks = 0;
  int rel, fn, gn, xn;
  int f_at, g_at, x_at, en_at;
  int viol = 0;
  logic en_wre;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  task automatic begin_t();
    rel = 0; fn = 0; gn = 0; xn = 0;
    f_at = -1; g_at = -1; x_at = -1;
    en_at = -1; en_wre = 1'bx;
  endtask

  task automatic sample();
    @(negedge clk);
    if (m_en && en_at < 0) begin
      en_at = rel;
      en_wre = m_wre;
    end
    if (f_bus.ack) begin fn++; f_at = rel; end
    if (g_bus.ack) begin gn++; g_at = rel; end
    if (x_bus.ack) begin xn++; x_at = rel; end
    if ((f_bus.ack && !f_bus.stb) ||
        (g_bus.ack && !g_bus.stb) ||
        (x_bus.ack && !x_bus.stb))
      viol++;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    rel++;
  endtask

  task automatic wait_for(input bit wf,
                          input bit wg,
                          input bit wx,
                          input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      sample();
      if ((!wf || fn > 0) && (!wg || gn > 0) &&
          (!wx || xn > 0)) begin
        ok = 1'b1;
        break;
      end
      next();
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic idle();
    f_bus.stb = 0; g_bus.stb = 0; x_bus.stb = 0;
    next();
    next();
  endtask

  initial begin
    f_bus.adr = 0; f_bus.stb = 0;
    f_bus.wre = 0; f_bus.dto = 0;
    g_bus.adr = 0; g_bus.stb = 0;
    g_bus.wre = 0; g_bus.dto = 0;
    x_bus.adr = 0; x_bus.stb = 0;
    x_bus.wre = 0; x_bus.dto = 0;

    @(posedge clk); #1;
    pre_en = 1; pre_adr = 16'h0010;
    pre_dat = 16'h1234;
    @(posedge clk); #1;
    pre_en = 0;
    @(negedge clk);
    chk("rst m_en", {31'd0, m_en}, 0);
    chk("rst m_adr", {16'd0, m_adr}, 0);
    chk("rst m_wre", {31'd0, m_wre}, 0);
    chk("rst m_dto", {16'd0, m_dto}, 0);
    chk("rst acks",
        {29'd0, f_bus.ack, g_bus.ack, x_bus.ack}, 0);
    chk("rst dti", {f_bus.dti, g_bus.dti}, 0);
    chk("rst xdti", {16'd0, x_bus.dti}, 0);
    @(posedge clk); #1;
    rst = 0;
    next();

    // 1: lone F read
    begin_t();
    f_bus.adr = 16'h0010; f_bus.wre = 0;
    f_bus.stb = 1;
    wait_for(1, 0, 0, "t1 timeout");
    chk("t1 en_at", en_at, 1);
    chk("t1 f_at", f_at, 3);
    chk("t1 f_dti", {16'd0, f_bus.dti}, 32'h1234);
    next();
    idle();
    chk("t1 gx acks", gn + xn, 0);

    // 2: F write + G read same address
    begin_t();
    f_bus.adr = 16'h0020; f_bus.wre = 1;
    f_bus.dto = 16'hBEEF; f_bus.stb = 1;
    g_bus.adr = 16'h0020; g_bus.wre = 0;
    g_bus.stb = 1;
    wait_for(1, 1, 0, "t2 timeout");
    chk("t2 first wre", {31'd0, en_wre}, 1);
    chk("t2 f_at", f_at, 6);
    chk("t2 g_at", g_at, 6);
    chk("t2 g_dti", {16'd0, g_bus.dti}, 32'hBEEF);
    chk("t2 f_dti kept", {16'd0, f_bus.dti},
        32'h1234);
    next();
    f_bus.wre = 0;
    idle();

    // 3: X write then X read
    begin_t();
    x_bus.adr = 16'h00FF; x_bus.wre = 1;
    x_bus.dto = 16'h5555; x_bus.stb = 1;
    wait_for(0, 0, 1, "t3w timeout");
    chk("t3w x_at", x_at, 3);
    next();
    idle();
    begin_t();
    x_bus.wre = 0; x_bus.stb = 1;
    wait_for(0, 0, 1, "t3r timeout");
    chk("t3r x_at", x_at, 3);
    chk("t3r x_dti", {16'd0, x_bus.dti}, 32'h5555);
    next();
    idle();

    // 4: X starved behind back-to-back CPU groups
    begin_t();
    x_bus.adr = 16'h0010; x_bus.wre = 0;
    x_bus.stb = 1;
    f_bus.adr = 16'h00FF; f_bus.stb = 1;
    g_bus.adr = 16'h0020; g_bus.stb = 1;
    wait_for(0, 0, 1, "t4 timeout");
    chk("t4 x_at", x_at, 31);
    chk("t4 cpu groups", {fn[15:0], gn[15:0]},
        {16'd4, 16'd4});
    chk("t4 x_dti", {16'd0, x_bus.dti}, 32'h1234);
    chk("t4 xcnt", {28'd0, dut.xcnt}, 0);
    next();
    idle();

    // 5: G strobe joins while F is captured
    begin_t();
    f_bus.adr = 16'h0010; f_bus.stb = 1;
    g_bus.adr = 16'h00FF; g_bus.stb = 0;
    sample(); next();
    sample(); next();
    g_bus.stb = 1;
    wait_for(1, 1, 0, "t5 timeout");
    chk("t5 f_at", f_at, 6);
    chk("t5 g_at", g_at, 6);
    chk("t5 dti", {f_bus.dti, g_bus.dti},
        32'h1234_5555);
    next();
    idle();

    // 6: reset during ACC
    begin_t();
    f_bus.adr = 16'h00FF; f_bus.stb = 1;
    sample(); next();
    rst = 1;
    sample(); next();
    rst = 0;
    sample();
    chk("t6 m_en", {31'd0, m_en}, 0);
    chk("t6 m_adr", {16'd0, m_adr}, 0);
    chk("t6 f_dti", {16'd0, f_bus.dti}, 0);
    chk("t6 acks",
        {29'd0, f_bus.ack, g_bus.ack, x_bus.ack}, 0);
    next();
    wait_for(1, 0, 0, "t6 timeout");
    chk("t6 f_at", f_at, 5);
    chk("t6 fn", fn, 1);
    chk("t6 f_dti", {16'd0, f_bus.dti}, 32'h5555);
    next();
    idle();

    chk("ack with stb low", viol, 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
